// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// One-entry pipeline slot between the EX and MEM stages of an in-order core.
// A valid EX instruction is captured into the slot when the slot is free
// (empty, or being drained by MEM in the same cycle) and no multiply/divide
// result is still outstanding. While an instruction cannot move forward,
// ex_stall freezes EX and everything upstream of it.
//
// Optional feature macro: M_SUPPORT_EN
//   defined   : mul/div wait tracking. An IDLE/WAIT FSM and a saturating wait
//               counter watch an outstanding mul/div. A sticky md_timeout is
//               raised once the wait reaches MD_TIMEOUT cycles.
//   undefined : ex_is_muldiv, mul_result_valid and div_result_valid are
//               ignored, no FSM or counter exists, and md_timeout is tied to 0.
//
// Parameters
//   XLEN        datapath width
//   MD_TIMEOUT  mul/div wait cycles before md_timeout is raised
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid              EX holds a valid instruction
//   ex_instr              EX instruction word (rd in [11:7], funct3 in [14:12])
//   ex_alu_out, ex_rd_wr  ALU result and register-write request
//   ex_store_data, ex_pc  rs2 value for stores, instruction PC
//   ex_is_muldiv          R-type M instruction in EX
//   mul_result_valid      multiplier result available
//   div_result_valid      divider result available
//   mem_ready             MEM accepts the held slot this cycle
//   flush                 kill the held slot and any pending mul/div wait
//   ex_stall              combinational freeze for EX and upstream
//   mem_*                 slot contents presented to MEM
//   md_timeout            sticky mul/div timeout error
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int XLEN       = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [31:0]     ex_instr,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic            ex_rd_wr,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_muldiv,
    input  logic            mul_result_valid,
    input  logic            div_result_valid,
    input  logic            mem_ready,
    input  logic            flush,
    output logic            ex_stall,
    output logic            mem_valid,
    output logic [31:0]     mem_instr,
    output logic [XLEN-1:0] mem_alu_out,
    output logic [XLEN-1:0] mem_store_data,
    output logic [XLEN-1:0] mem_pc,
    output logic            mem_rd_wr,
    output logic [4:0]      mem_rd,
    output logic            md_timeout
);

    // -----------------------------------------------------------------------
    // Slot state
    // -----------------------------------------------------------------------
    logic            mem_valid_q;
    logic            mem_valid_d;
    logic [31:0]     instr_q;
    logic [31:0]     instr_d;
    logic [XLEN-1:0] alu_out_q;
    logic [XLEN-1:0] alu_out_d;
    logic [XLEN-1:0] store_data_q;
    logic [XLEN-1:0] store_data_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            rd_wr_q;
    logic            rd_wr_d;

    logic            slot_free;
    logic            md_pending;
    logic            capture;

    // The slot can take a new instruction if it is empty or MEM drains it in
    // this same cycle. That second case is what gives back-to-back flow with
    // no bubble.
    assign slot_free = ~mem_valid_q | mem_ready;

    // Flush wins over everything: EX is released in the flush cycle so the
    // upstream redirect can proceed.
    assign ex_stall  = ~flush & ex_valid & (md_pending | ~slot_free);
    assign capture   = ex_valid & ~ex_stall & ~flush;

    // -----------------------------------------------------------------------
    // Optional mul/div wait tracking
    // -----------------------------------------------------------------------
`ifdef M_SUPPORT_EN
    localparam int              CNT_W   = $clog2(MD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } md_state_t;

    md_state_t        state_q;
    md_state_t        state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             md_timeout_q;
    logic             md_timeout_d;
    logic             md_done;

    // funct3[2] separates the divide/remainder group from the multiply group.
    assign md_done    = ex_instr[14] ? div_result_valid : mul_result_valid;
    assign md_pending = ex_valid & ex_is_muldiv & ~md_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        if (flush) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_d = '0;
                    if (md_pending) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (md_done) begin
                        state_d    = IDLE;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end
            endcase
        end

        // Sticky: raised on the edge where the counter reaches the limit and
        // only cleared by reset. ex_stall keeps following md_pending, so the
        // pipeline stays frozen after the error is flagged.
        md_timeout_d = md_timeout_q | (wait_cnt_d == CNT_MAX);
    end

    assign md_timeout = md_timeout_q;
`else
    // Without M support these inputs carry no meaning for this stage.
    logic unused_md_inputs;
    assign unused_md_inputs = ex_is_muldiv ^ mul_result_valid ^ div_result_valid;

    assign md_pending = 1'b0;
    assign md_timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Slot next-state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_valid_d = mem_valid_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (capture) begin
            mem_valid_d = 1'b1;
        end else if (mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    // Data registers only move on a capture; a drain leaves them in place.
    always_comb begin
        instr_d      = instr_q;
        alu_out_d    = alu_out_q;
        store_data_d = store_data_q;
        pc_d         = pc_q;
        rd_wr_d      = rd_wr_q;
        if (capture) begin
            instr_d      = ex_instr;
            alu_out_d    = ex_alu_out;
            store_data_d = ex_store_data;
            pc_d         = ex_pc;
            // Writes to x0 are dropped here so MEM/WB never see them.
            rd_wr_d      = ex_rd_wr & (ex_instr[11:7] != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q  <= 1'b0;
            instr_q      <= '0;
            alu_out_q    <= '0;
            store_data_q <= '0;
            pc_q         <= '0;
            rd_wr_q      <= 1'b0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            instr_q      <= instr_d;
            alu_out_q    <= alu_out_d;
            store_data_q <= store_data_d;
            pc_q         <= pc_d;
            rd_wr_q      <= rd_wr_d;
        end
    end

    assign mem_valid      = mem_valid_q;
    assign mem_instr      = instr_q;
    assign mem_alu_out    = alu_out_q;
    assign mem_store_data = store_data_q;
    assign mem_pc         = pc_q;
    assign mem_rd_wr      = rd_wr_q;
    assign mem_rd         = instr_q[11:7];

endmodule

// File: tb/tb_ex_mem_stage.sv
`timescale 1ns/1ps
module tb_ex_mem_stage;

    localparam int XLEN  = 32;
    localparam int MD_TO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid;
    logic [31:0]     ex_instr;
    logic [XLEN-1:0] ex_alu_out;
    logic            ex_rd_wr;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic            ex_is_muldiv;
    logic            mul_result_valid;
    logic            div_result_valid;
    logic            mem_ready;
    logic            flush;
    logic            ex_stall;
    logic            mem_valid;
    logic [31:0]     mem_instr;
    logic [XLEN-1:0] mem_alu_out;
    logic [XLEN-1:0] mem_store_data;
    logic [XLEN-1:0] mem_pc;
    logic            mem_rd_wr;
    logic [4:0]      mem_rd;
    logic            md_timeout;

    ex_mem_stage #(.XLEN(XLEN), .MD_TIMEOUT(MD_TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_instr         (ex_instr),
        .ex_alu_out       (ex_alu_out),
        .ex_rd_wr         (ex_rd_wr),
        .ex_store_data    (ex_store_data),
        .ex_pc            (ex_pc),
        .ex_is_muldiv     (ex_is_muldiv),
        .mul_result_valid (mul_result_valid),
        .div_result_valid (div_result_valid),
        .mem_ready        (mem_ready),
        .flush            (flush),
        .ex_stall         (ex_stall),
        .mem_valid        (mem_valid),
        .mem_instr        (mem_instr),
        .mem_alu_out      (mem_alu_out),
        .mem_store_data   (mem_store_data),
        .mem_pc           (mem_pc),
        .mem_rd_wr        (mem_rd_wr),
        .mem_rd           (mem_rd),
        .md_timeout       (md_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sd;
        logic [XLEN-1:0] pc;
        logic            rd_wr;
        logic [4:0]      rd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic push_exp(input logic [31:0] instr, input logic [XLEN-1:0] alu,
                            input logic rdwr, input logic [XLEN-1:0] sd,
                            input logic [XLEN-1:0] pc);
        exp_t e;
        logic [4:0] rd;
        rd       = instr[11:7];
        e.instr  = instr;
        e.alu    = alu;
        e.sd     = sd;
        e.pc     = pc;
        e.rd     = rd;
        e.rd_wr  = rdwr && (rd != 5'd0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [XLEN-1:0] alu,
                         input logic rdwr, input logic [XLEN-1:0] sd,
                         input logic [XLEN-1:0] pc);
        ex_valid      = 1'b1;
        ex_instr      = instr;
        ex_alu_out    = alu;
        ex_rd_wr      = rdwr;
        ex_store_data = sd;
        ex_pc         = pc;
    endtask

    // Holds an instruction in EX until it is accepted (bounded), then drops
    // ex_valid. Called and returns at posedge+1.
    task automatic send(input logic [31:0] instr, input logic [XLEN-1:0] alu,
                        input logic rdwr, input logic [XLEN-1:0] sd,
                        input logic [XLEN-1:0] pc, input bit rand_ready);
        int waited;
        waited = 0;
        drive(instr, alu, rdwr, sd, pc);
        forever begin
            if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!ex_stall) begin
                push_exp(instr, alu, rdwr, sd, pc);
                @(posedge clk); #1;
                ex_valid = 1'b0;
                break;
            end
            waited++;
            if (waited > 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_accept: ex_stall stuck at %b, required 0 within 200 cycles", ex_stall);
                @(posedge clk); #1;
                ex_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: the slot is consumed on the edge following a negedge where
    // it is valid and MEM is ready.
    always @(negedge clk) begin
        if (mon_en && rst_n && mem_valid && mem_ready && !flush) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got alu=%h pc=%h, required no output", mem_alu_out, mem_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_instr, mem_alu_out, mem_store_data, mem_pc} !== {mon_e.instr, mon_e.alu, mon_e.sd, mon_e.pc}) begin
                    n_fail++;
                    $display("FAIL sb_data: got instr=%h alu=%h sd=%h pc=%h, required instr=%h alu=%h sd=%h pc=%h",
                             mem_instr, mem_alu_out, mem_store_data, mem_pc,
                             mon_e.instr, mon_e.alu, mon_e.sd, mon_e.pc);
                end
                n_tests++;
                if ({mem_rd_wr, mem_rd} !== {mon_e.rd_wr, mon_e.rd}) begin
                    n_fail++;
                    $display("FAIL sb_rd: got rd_wr=%b rd=%0d, required rd_wr=%b rd=%0d",
                             mem_rd_wr, mem_rd, mon_e.rd_wr, mon_e.rd);
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; ex_valid = 1'b1; ex_instr = rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd9);
        ex_alu_out = 32'hDEAD_BEEF; ex_rd_wr = 1'b1; ex_store_data = 32'h1234; ex_pc = 32'h40;
        ex_is_muldiv = 1'b0; mul_result_valid = 1'b0; div_result_valid = 1'b0;
        mem_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_rd_wr, md_timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got vld/rdwr/to=%b%b%b, required 000", mem_valid, mem_rd_wr, md_timeout);
        end
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b, required 0", ex_stall);
        end
        n_tests++;
        if ({mem_instr, mem_alu_out, mem_store_data, mem_pc, mem_rd} !== '0) begin
            n_fail++; $display("FAIL reset_data: got alu=%h instr=%h pc=%h, required 0", mem_alu_out, mem_instr, mem_pc);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; ex_valid = 1'b0; mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        logic [31:0] add_i;
        add_i = rtype(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
        mem_ready = 1'b1;
        drive(add_i, 32'h5, 1'b1, 32'h11, 32'h100);
        @(negedge clk);
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL add_stall: got %b, required 0", ex_stall);
        end
        push_exp(add_i, 32'h5, 1'b1, 32'h11, 32'h100);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_alu_out, mem_rd_wr, mem_rd} !== {1'b1, 32'h5, 1'b1, 5'd3}) begin
            n_fail++; $display("FAIL add_slot: got vld=%b alu=%h rdwr=%b rd=%0d, required vld=1 alu=5 rdwr=1 rd=3",
                               mem_valid, mem_alu_out, mem_rd_wr, mem_rd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_drain: got mem_valid=%b, required 0", mem_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [31:0] ia, ib;
        ia = rtype(7'd0, 5'd4, 5'd5, 3'd0, 5'd6);
        ib = rtype(7'd32, 5'd7, 5'd8, 3'd0, 5'd10);
        mem_ready = 1'b0;
        drive(ia, 32'hAAAA_0001, 1'b1, 32'h21, 32'h200);
        @(negedge clk);
        push_exp(ia, 32'hAAAA_0001, 1'b1, 32'h21, 32'h200);
        @(posedge clk); #1;
        drive(ib, 32'hBBBB_0002, 1'b1, 32'h22, 32'h204);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ex_stall, mem_valid, mem_alu_out} !== {1'b1, 1'b1, 32'hAAAA_0001}) begin
                n_fail++; $display("FAIL bp_hold%0d: got stall=%b vld=%b alu=%h, required stall=1 vld=1 alu=aaaa0001",
                                   i, ex_stall, mem_valid, mem_alu_out);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got ex_stall=%b, required 0", ex_stall);
        end
        push_exp(ib, 32'hBBBB_0002, 1'b1, 32'h22, 32'h204);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_alu_out} !== {1'b1, 32'hBBBB_0002}) begin
            n_fail++; $display("FAIL bp_zero_bubble: got vld=%b alu=%h, required vld=1 alu=bbbb0002", mem_valid, mem_alu_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 12; k++) begin
            send(rtype(7'd0, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom)),
                 $urandom, 1'($urandom), $urandom, 32'h1000 + 32'(k * 4), 1'b1);
        end
        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_tests++;
        if (exp_q.size() !== 0 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got %0d pending, mem_valid=%b, required 0 pending and 0", exp_q.size(), mem_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rd_zero;
        mem_ready = 1'b1;
        send(rtype(7'd0, 5'd3, 5'd4, 3'd0, 5'd0), 32'h77, 1'b1, 32'h0, 32'h300, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_rd_wr} !== 2'b10) begin
            n_fail++; $display("FAIL rd_zero: got vld=%b rd_wr=%b, required vld=1 rd_wr=0", mem_valid, mem_rd_wr);
        end
        @(posedge clk); #1;
        send(rtype(7'd0, 5'd3, 5'd4, 3'd0, 5'd7), 32'h78, 1'b0, 32'h0, 32'h304, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_rd_wr, mem_rd} !== {1'b1, 1'b0, 5'd7}) begin
            n_fail++; $display("FAIL rd_nowr: got vld=%b rd_wr=%b rd=%0d, required 1 0 7", mem_valid, mem_rd_wr, mem_rd);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        logic [31:0] ia;
        ia = rtype(7'd0, 5'd1, 5'd2, 3'd0, 5'd12);
        mem_ready = 1'b0;
        send(ia, 32'hF00D, 1'b1, 32'h5, 32'h400, 1'b0);
        drive(rtype(7'd1, 5'd3, 5'd4, 3'd0, 5'd13), 32'hCAFE, 1'b1, 32'h6, 32'h404);
        ex_is_muldiv = 1'b1; mul_result_valid = 1'b0; div_result_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ex_stall !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre_stall: got %b, required 1", ex_stall);
        end
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b, required 0 in flush cycle", ex_stall);
        end
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({mem_valid, md_timeout, ex_stall} !== 3'b000) begin
            n_fail++; $display("FAIL flush_after: got vld=%b to=%b stall=%b, required 000", mem_valid, md_timeout, ex_stall);
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef M_SUPPORT_EN
    task automatic test_div_latency;
        logic [31:0] di;
        int  stall_cnt;
        bit  done;
        di = rtype(7'd1, 5'd5, 5'd6, 3'b100, 5'd14);
        stall_cnt = 0; done = 0;
        mem_ready = 1'b1;
        drive(di, 32'h0000_0D1F, 1'b1, 32'h7, 32'h500);
        ex_is_muldiv = 1'b1; mul_result_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            div_result_valid = (i >= 33);
            @(negedge clk);
            if (ex_stall) stall_cnt++;
            else begin
                push_exp(di, 32'h0000_0D1F, 1'b1, 32'h7, 32'h500);
                @(posedge clk); #1;
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0; ex_is_muldiv = 1'b0; div_result_valid = 1'b0; mul_result_valid = 1'b0;
        n_tests++;
        if (!done || stall_cnt !== 33) begin
            n_fail++; $display("FAIL div_stall_cycles: got %0d (accepted=%0d), required 33", stall_cnt, done);
        end
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_alu_out, md_timeout} !== {1'b1, 32'h0000_0D1F, 1'b0}) begin
            n_fail++; $display("FAIL div_capture: got vld=%b alu=%h to=%b, required 1 00000d1f 0", mem_valid, mem_alu_out, md_timeout);
        end
        repeat (70) begin @(posedge clk); #1; end
        @(negedge clk);
        n_tests++;
        if (md_timeout !== 1'b0) begin
            n_fail++; $display("FAIL div_idle: got md_timeout=%b after idle, required 0", md_timeout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_timeout;
        logic exp_to;
        mem_ready = 1'b1;
        drive(rtype(7'd1, 5'd8, 5'd9, 3'b000, 5'd15), 32'h1111, 1'b1, 32'h8, 32'h600);
        ex_is_muldiv = 1'b1; mul_result_valid = 1'b0; div_result_valid = 1'b1;
        for (int i = 0; i <= MD_TO + 4; i++) begin
            @(negedge clk);
            exp_to = (i >= MD_TO + 1);
            n_tests++;
            if ({ex_stall, md_timeout} !== {1'b1, exp_to}) begin
                n_fail++; $display("FAIL mul_timeout_c%0d: got stall=%b to=%b, required stall=1 to=%b", i, ex_stall, md_timeout, exp_to);
            end
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0; div_result_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({md_timeout, ex_stall, mem_valid} !== 3'b100) begin
            n_fail++; $display("FAIL mul_timeout_sticky: got to=%b stall=%b vld=%b, required 1 0 0", md_timeout, ex_stall, mem_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (md_timeout !== 1'b0) begin
            n_fail++; $display("FAIL mul_timeout_reset: got %b, required 0", md_timeout);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_muldiv_ignored;
        mem_ready = 1'b1;
        drive(rtype(7'd1, 5'd8, 5'd9, 3'b100, 5'd16), 32'h2222, 1'b1, 32'h9, 32'h700);
        ex_is_muldiv = 1'b1; mul_result_valid = 1'b0; div_result_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++; $display("FAIL muldiv_ignored_stall: got %b, required 0", ex_stall);
        end
        push_exp(ex_instr, 32'h2222, 1'b1, 32'h9, 32'h700);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_muldiv = 1'b0;
        repeat (MD_TO + 4) begin @(posedge clk); #1; end
        @(negedge clk);
        n_tests++;
        if ({md_timeout, mem_valid} !== 2'b00) begin
            n_fail++; $display("FAIL muldiv_ignored_to: got to=%b vld=%b, required 00", md_timeout, mem_valid);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_async_reset;
        mem_ready = 1'b0;
        send(rtype(7'd0, 5'd1, 5'd1, 3'd0, 5'd17), 32'h3333, 1'b1, 32'hA, 32'h800, 1'b0);
        @(negedge clk);
        n_tests++;
        if (mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre: got mem_valid=%b, required 1", mem_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_valid, mem_rd_wr, mem_alu_out} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL arst_no_edge: got vld=%b rdwr=%b alu=%h, required 0 0 0", mem_valid, mem_rd_wr, mem_alu_out);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
        test_rd_zero();
`ifdef M_SUPPORT_EN
        test_div_latency();
        test_flush();
        test_mul_timeout();
`else
        test_flush();
        test_muldiv_ignored();
`endif
        test_async_reset();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter MD_TIMEOUT, default 64, max mul/div wait cycles before flagging an error.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ex_valid, input, 1, EX holds a valid instruction.
REQ-006 SHALL have port ex_instr, input, 32, EX instruction word (instr_t).
REQ-007 SHALL have ports ex_alu_out (input, XLEN, ALU c_out) and ex_rd_wr (input, 1, ALU rd_wr).
REQ-008 SHALL have ports ex_store_data (input, XLEN, rs2 value) and ex_pc (input, XLEN, instruction PC).
REQ-009 SHALL have port ex_is_muldiv, input, 1, R-type M_INSTR in EX.
REQ-010 SHALL have ports mul_result_valid and div_result_valid, input, 1 each, from ALU.
REQ-011 SHALL have port mem_ready, input, 1, MEM accepts the held slot this cycle.
REQ-012 SHALL have port flush, input, 1, kill the held slot and any pending wait.
REQ-013 SHALL have port ex_stall, output, 1, freeze EX and upstream stages.
REQ-014 SHALL have ports mem_valid (output, 1), mem_instr (output, 32), mem_alu_out, mem_store_data and mem_pc (output, XLEN each), mem_rd_wr (output, 1), mem_rd (output, 5).
REQ-015 SHALL have port md_timeout, output, 1, sticky mul/div timeout error.

Function
REQ-016 SHALL define slot_free = !mem_valid | mem_ready.
REQ-017 SHALL define md_done = ex_instr.funct3[2] ? div_result_valid : mul_result_valid, and md_pending = ex_valid & ex_is_muldiv & !md_done.
REQ-018 SHALL drive ex_stall combinationally = !flush & ex_valid & (md_pending | !slot_free).
REQ-019 SHALL capture all ex_* fields into the slot, setting mem_valid=1 next cycle, when ex_valid & !ex_stall & !flush.
REQ-020 SHALL clear mem_valid when mem_valid & mem_ready and no capture occurs in the same cycle; a simultaneous drain and capture SHALL keep mem_valid=1 with new data (zero-bubble).
REQ-021 SHALL hold all slot data registers unchanged when not capturing.
REQ-022 SHALL set mem_rd = captured ex_instr[11:7] and mem_rd_wr = captured ex_rd_wr & (rd != 0).
REQ-023 SHALL implement FSM IDLE/WAIT: IDLE->WAIT when md_pending & !flush; WAIT->IDLE when md_done or flush; otherwise stay.
REQ-024 SHALL clear wait counter on IDLE and increment it each WAIT cycle, saturating at MD_TIMEOUT.
REQ-025 SHALL set md_timeout when the counter reaches MD_TIMEOUT, holding it until reset; ex_stall stays asserted while md_pending.
REQ-026 SHALL, on flush, clear mem_valid next cycle, force FSM to IDLE, clear the counter; flush SHALL override capture and mem_ready.
REQ-027 SHALL treat an ex_valid=0 cycle as a bubble: no capture, ex_stall=0.

Reset
REQ-028 SHALL, while rst_n=0, force mem_valid=0, mem_rd_wr=0, md_timeout=0, FSM=IDLE, counter=0, all data outputs=0.
REQ-029 SHALL, on reset assertion mid-wait or mid-hold, discard state immediately, without waiting for a clock edge.
REQ-030 SHALL leave ex_stall combinational; it SHALL read 0 in reset because mem_valid=0 and the FSM is IDLE, provided ex_is_muldiv=0.

Configuration
REQ-031 SHALL, with M_SUPPORT_EN defined, implement REQ-017, REQ-023 to REQ-025 as written.
REQ-032 SHALL, without M_SUPPORT_EN, ignore ex_is_muldiv, mul_result_valid and div_result_valid, omit FSM and counter, treat md_pending=0, and tie md_timeout=0.

Verification
REQ-033 SHALL cover: ADD, ex_alu_out=0x5, rd=3, mem_ready=1 -> mem_valid=1 next cycle, mem_alu_out=0x5, mem_rd_wr=1, ex_stall=0.
REQ-034 SHALL cover: mem_ready=0 with slot full plus new ex_valid -> ex_stall=1, slot data unchanged; mem_ready=1 -> new data captured same edge, mem_valid stays 1.
REQ-035 SHALL cover: DIV with div_result_valid rising after 33 cycles -> ex_stall=1 for exactly 33 cycles, then capture of c_out, FSM IDLE, md_timeout=0.
REQ-036 SHALL cover: MUL with mul_result_valid never rising, MD_TIMEOUT=64 -> md_timeout=1 after 64 WAIT cycles, remains 1, ex_stall held.
REQ-037 SHALL cover: flush during WAIT with slot full -> mem_valid=0, FSM IDLE, counter 0 next cycle, ex_stall=0 in flush cycle.
REQ-038 SHALL cover: instruction with rd=0 and ex_rd_wr=1 -> mem_rd_wr=0; rst_n low mid-hold -> mem_valid=0 without a clock edge.
